// File: rtl/sd_rx_pkt_arb.sv
// Packet-atomic round-robin merge of NUM_PORTS RX MAC streams into one PCC stream.
// Stray non-SOP beats are drained and stalled packets are aborted with BADEOP.
module sd_rx_pkt_arb #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned PW        = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   rxg_srdy,
    output logic [NUM_PORTS-1:0]   rxg_drdy,
    input  logic [2*NUM_PORTS-1:0] rxg_code,
    input  logic [8*NUM_PORTS-1:0] rxg_data,
    output logic                   arb_srdy,
    input  logic                   arb_drdy,
    output logic [1:0]             arb_code,
    output logic [7:0]             arb_data,
    output logic [PW-1:0]          arb_port,
    output logic [15:0]            drop_count
);

    localparam logic [1:0] PCC_DATA   = 2'd0;
    localparam logic [1:0] PCC_SOP    = 2'd1;
    localparam logic [1:0] PCC_EOP    = 2'd2;
    localparam logic [1:0] PCC_BADEOP = 2'd3;

    localparam int unsigned TW  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam int unsigned DCW = $clog2(NUM_PORTS + 1);

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StPkt   = 4'b0010,
        StAbort = 4'b0100,
        StFlush = 4'b1000
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic                 ic_srdy;
    logic                 ic_drdy;
    logic [1:0]           ic_code;
    logic [7:0]           ic_data;
    logic [PW-1:0]        ic_port;
    logic [NUM_PORTS-1:0] drdy_c;
    logic [DCW-1:0]       ndrop;
    logic [16:0]          drop_sum;

    logic                 found;
    logic [PW-1:0]        cand;
    logic                 g_srdy;
    logic [1:0]           g_code;
    logic [7:0]           g_data;
    logic [PW-1:0]        rr_next;

    assign ic_drdy  = !arb_srdy || arb_drdy;
    assign rxg_drdy = reset ? '0 : drdy_c;
    assign g_srdy   = rxg_srdy[grant_q];
    assign g_code   = rxg_code[2*grant_q +: 2];
    assign g_data   = rxg_data[8*grant_q +: 8];
    assign rr_next  = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);
    assign drop_sum = {1'b0, drop_count} + 17'(ndrop);

    // First SOP candidate at or after rr_q, wrapping.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            int idx;
            idx = (int'(rr_q) + k) % int'(NUM_PORTS);
            if (!found && rxg_srdy[idx] && rxg_code[2*idx +: 2] == PCC_SOP) begin
                found = 1'b1;
                cand  = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        timer_d = timer_q;
        drdy_c  = '0;
        ic_srdy = 1'b0;
        ic_code = PCC_DATA;
        ic_data = 8'h00;
        ic_port = grant_q;
        ndrop   = '0;

        // Stray drain: the granted port is exempt outside IDLE.
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (rxg_srdy[i] && rxg_code[2*i +: 2] != PCC_SOP &&
                (state_q == StIdle || PW'(i) != grant_q)) begin
                drdy_c[i] = 1'b1;
                ndrop     = ndrop + DCW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (found && ic_drdy) begin
                    drdy_c[cand] = 1'b1;
                    ic_srdy      = 1'b1;
                    ic_code      = PCC_SOP;
                    ic_data      = rxg_data[8*cand +: 8];
                    ic_port      = cand;
                    grant_d      = cand;
                    timer_d      = '0;
                    state_d      = StPkt;
                end
            end
            StPkt: begin
                if (g_srdy) begin
                    if (g_code == PCC_SOP) begin
                        // Truncate the open packet; the new SOP stays put and re-arbitrates.
                        ic_srdy = 1'b1;
                        ic_code = PCC_BADEOP;
                        if (ic_drdy) begin
                            state_d = StIdle;
                            rr_d    = rr_next;
                        end
                    end else begin
                        drdy_c[grant_q] = ic_drdy;
                        ic_srdy         = 1'b1;
                        ic_code         = g_code;
                        ic_data         = g_data;
                        if (ic_drdy) begin
                            timer_d = '0;
                            if (g_code == PCC_EOP || g_code == PCC_BADEOP) begin
                                state_d = StIdle;
                                rr_d    = rr_next;
                            end
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    if (timer_q == TW'(TIMEOUT)) begin
                        state_d = StAbort;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            StAbort: begin
                ic_srdy = 1'b1;
                ic_code = PCC_BADEOP;
                if (ic_drdy) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (g_srdy) begin
                    if (g_code == PCC_SOP) begin
                        state_d = StIdle;
                        rr_d    = rr_next;
                    end else begin
                        drdy_c[grant_q] = 1'b1;
                        ndrop           = ndrop + DCW'(1);
                        if (g_code == PCC_EOP || g_code == PCC_BADEOP) begin
                            state_d = StIdle;
                            rr_d    = rr_next;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            grant_q    <= '0;
            timer_q    <= '0;
            drop_count <= 16'h0000;
            arb_srdy   <= 1'b0;
            arb_code   <= 2'b00;
            arb_data   <= 8'h00;
            arb_port   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            timer_q    <= timer_d;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (ic_srdy && ic_drdy) begin
                arb_srdy <= 1'b1;
                arb_code <= ic_code;
                arb_data <= ic_data;
                arb_port <= ic_port;
            end else if (arb_drdy) begin
                arb_srdy <= 1'b0;
            end
        end
    end

endmodule
